keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Sequences the 4x4 keypad: drives one-hot rows, waits a settle time, samples synchronised
//  columns, debounces, emits one key code per press on a valid/ready handshake, then waits
//  for a debounced release. Sits between keypad pins and the digit recorder / 7-seg path.
// PARAMETERS
//  SETTLE_CYCLES  16  clk cycles per row between row change and column sample (>=1)
//  DB_CYCLES      4   consecutive identical samples needed for press and for release (>=1)
//  REPEAT_CYCLES  50000  hold time before auto-repeat (only with KEYPAD_REPEAT_EN)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  scan_en    in   1  1 = scanning runs; 0 = freeze in SETTLE/SCAN (rows, counters held)
//  col        in   4  raw keypad columns, active-high, asynchronous to clk
//  rows       out  4  one-hot active-high row drive
//  key_code   out  4  hex code of accepted key, stable while key_valid=1
//  key_valid  out  1  key_code available
//  key_ready  in   1  consumer accepts key_code when key_valid&key_ready
//  busy       out  1  1 in DEBOUNCE/EMIT/RELEASE
// BEHAVIOUR
//  - Reset: rows=4'b0001, key_code=0, key_valid=0, busy=0, state=SETTLE, counter=0, sync flops=0.
//  - col passes a 2-flop synchroniser (col_s); all decisions use col_s (2-cycle input latency).
//  - Decode (row, highest set col bit wins): row0 bit3..0=A,3,2,1; row1=B,6,5,4;
//    row2=C,9,8,7; row3=D,F,0,E. col_s==0 -> no key.
//  - SETTLE: counter++ each cycle; at counter==SETTLE_CYCLES-1 -> SCAN, counter=0.
//  - SCAN (1 cycle): col_s!=0 -> capture code, DEBOUNCE, counter=0; else rows rotate left
//    (4'b1000 wraps to 4'b0001) -> SETTLE.
//  - DEBOUNCE: rows held; decode==captured -> counter++, at DB_CYCLES-1 -> EMIT;
//    any mismatch (incl. no key) -> rotate row, SETTLE. Counter restarts on entry.
//  - EMIT: key_valid=1, key_code=captured; on key_valid&key_ready -> key_valid=0 next cycle,
//    RELEASE. key_code never changes while key_valid=1. Press->key_valid latency from col_s
//    stable = 1 (SCAN) + DB_CYCLES cycles.
//  - RELEASE: rows held; col_s==0 -> counter++, at DB_CYCLES-1 -> rotate row, SETTLE;
//    col_s!=0 resets counter. Second key pressed while first held: ignored (no emission).
//  - scan_en=0 in DEBOUNCE/EMIT/RELEASE: current sequence completes, then freeze at SETTLE.
//  - Counters 16 bit, saturate never required (parameters < 2^16). busy = state not in
//    {SETTLE, SCAN}.
//  - reset asserted mid-operation: all state returns to reset values immediately; a pending
//    key_valid is dropped.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in RELEASE, if col_s continuously equals captured code for
//    REPEAT_CYCLES cycles -> EMIT same code again (counter restarts each repeat).
//  KEYPAD_REPEAT_EN undefined: exactly one emission per press; REPEAT_CYCLES unused.
// TESTING
//  1 reset=0 then 1, no keys -> rows cycles 0001,0010,0100,1000,0001, each held
//    SETTLE_CYCLES+1 clk; key_valid stays 0.
//  2 press row1/col bit2 stable, key_ready=1 -> single key_valid pulse, key_code=4'h6;
//    release -> scanning resumes at row2 after DB_CYCLES zero samples.
//  3 row3/col bit1 press bouncing (toggles every 2 clk, DB_CYCLES=4) then stable ->
//    no emission during bounce, exactly one key_code=4'h0 after stable.
//  4 press row0 col=4'b1001, key_ready=0 for 20 cycles -> key_valid held, key_code=4'hA
//    stable 20 cycles; accepted on first ready cycle, key_valid=0 next cycle.
//  5 reset=0 asserted while in EMIT -> key_valid=0, rows=0001 immediately.
//  6 KEYPAD_REPEAT_EN, REPEAT_CYCLES=100, hold row2/col bit0 350 cycles -> code 4'h7
//    emitted 1+3 times; without macro exactly once.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with debounce and a valid/ready key port.
// Define KEYPAD_REPEAT_EN to build the hold-to-repeat path.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] col,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       busy
);

  localparam logic [2:0] SETTLE   = 3'd0;
  localparam logic [2:0] SCAN     = 3'd1;
  localparam logic [2:0] DEBOUNCE = 3'd2;
  localparam logic [2:0] EMIT     = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DB_LAST  = 16'(DB_CYCLES - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [3:0]  col_m;
  logic [3:0]  col_s;
  logic [3:0]  dec;
  logic [3:0]  rot;
  logic        key_on;
  logic        same;
  logic        rpt_hit;

  function automatic logic [3:0] decode(
    input logic [3:0] r,
    input logic [3:0] c
  );
    logic [1:0] ri;
    logic [1:0] ci;
    logic [3:0] k;
    ri = 2'd0;
    unique case (1'b1)
      r[3]:    ri = 2'd3;
      r[2]:    ri = 2'd2;
      r[1]:    ri = 2'd1;
      default: ri = 2'd0;
    endcase
    // highest asserted column wins
    if (c[3])      ci = 2'd3;
    else if (c[2]) ci = 2'd2;
    else if (c[1]) ci = 2'd1;
    else           ci = 2'd0;
    case ({ri, ci})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'hE;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m <= 4'b0;
      col_s <= 4'b0;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  assign dec    = decode(rows, col_s);
  assign key_on = |col_s;
  assign same   = key_on && (dec == key_code);
  assign rot    = {rows[2:0], rows[3]};
  assign busy   = (state != SETTLE) && (state != SCAN);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);

  logic [15:0] rpt_cnt;

  assign rpt_hit = (state == RELEASE) && same &&
                   (rpt_cnt == RPT_LAST);

  // restarts whenever the held key drops or a repeat fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= 16'd0;
    end else if ((state == RELEASE) && same && !rpt_hit) begin
      rpt_cnt <= rpt_cnt + 16'd1;
    end else begin
      rpt_cnt <= 16'd0;
    end
  end
`else
  logic unused_rpt;

  assign unused_rpt = ^REPEAT_CYCLES;
  assign rpt_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SETTLE;
      cnt       <= 16'd0;
      rows      <= 4'b0001;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (scan_en) begin
            if (cnt == SET_LAST) begin
              state <= SCAN;
              cnt   <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        SCAN: begin
          if (scan_en) begin
            if (key_on) begin
              key_code <= dec;
              state    <= DEBOUNCE;
              cnt      <= 16'd0;
            end else begin
              rows  <= rot;
              state <= SETTLE;
            end
          end
        end
        DEBOUNCE: begin
          if (same) begin
            if (cnt == DB_LAST) begin
              state     <= EMIT;
              key_valid <= 1'b1;
              cnt       <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            rows  <= rot;
            state <= SETTLE;
            cnt   <= 16'd0;
          end
        end
        EMIT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            state     <= RELEASE;
            cnt       <= 16'd0;
          end
        end
        RELEASE: begin
          if (!key_on) begin
            if (cnt == DB_LAST) begin
              rows  <= rot;
              state <= SETTLE;
              cnt   <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else if (rpt_hit) begin
            state     <= EMIT;
            key_valid <= 1'b1;
            cnt       <= 16'd0;
          end else begin
            cnt <= 16'd0;
          end
        end
        default: begin
          state     <= SETTLE;
          cnt       <= 16'd0;
          key_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl with a keypad matrix model.
// Expected key codes are queued at press time and popped on each handshake.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int SC = 16;
  localparam int DB = 4;
  localparam int RP = 100;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_N = 4;
`else
  localparam int REP_N = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [3:0] col;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       busy;

  logic       key_on;
  logic [1:0] key_row;
  logic [3:0] key_mask;

  int cmp_n = 0;
  int err_n = 0;
  int hs_n  = 0;

  logic [3:0] sb[$];
  logic       pv = 1'b0;
  logic [3:0] pc = 4'h0;

  always #5 clk = ~clk;

  assign col = (key_on && rows[key_row]) ? key_mask : 4'b0;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(SC),
    .DB_CYCLES(DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scan_en(scan_en),
    .col(col),
    .rows(rows),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] t);
    int n;
    n = 0;
    while (rows == t && n < 200) begin cyc(1); n++; end
    while (rows != t && n < 200) begin cyc(1); n++; end
    chk("wait_row_timeout", n < 200, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 300) begin cyc(1); n++; end
    chk(tag, key_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin cyc(1); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  // scoreboard side: every accepted key pops one expected code
  always @(negedge clk) begin
    #1;
    if (reset === 1'b1 && key_valid === 1'b1) begin
      if (pv) chk("code_stable", key_code, pc);
      if (key_ready === 1'b1) begin
        hs_n++;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("key_code", key_code, sb.pop_front());
      end
    end
    pv = (reset === 1'b1) && (key_valid === 1'b1);
    pc = key_code;
  end

  initial begin
    #500000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int h0;
    logic [3:0] prev;
    logic [3:0] rseq[4];
    rseq[0] = 4'b0010;
    rseq[1] = 4'b0100;
    rseq[2] = 4'b1000;
    rseq[3] = 4'b0001;

    reset = 1'b0;
    scan_en = 1'b1;
    key_ready = 1'b1;
    key_on = 1'b0;
    key_row = 2'd0;
    key_mask = 4'b0;
    cyc(3);
    chk("rst_rows", rows, 4'b0001);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // idle scan: each row held SETTLE+1 cycles
    for (int i = 0; i < 4; i++) begin
      prev = rows;
      n = 0;
      do begin cyc(1); n++; end while (rows == prev && n < 100);
      chk("row_hold", n, SC + 1);
      chk("row_next", rows, rseq[i]);
    end
    chk("idle_no_key", hs_n, 0);

    scan_en = 1'b0;
    cyc(40);
    chk("freeze_rows", rows, 4'b0001);
    chk("freeze_busy", busy, 0);
    scan_en = 1'b1;

    // single clean press of '6'
    wait_row(4'b0010);
    key_row = 2'd1;
    key_mask = 4'b0100;
    key_on = 1'b1;
    sb.push_back(4'h6);
    h0 = hs_n;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin cyc(1); n++; end
    chk("press_latency", n, SC + 1 + DB);
    cyc(1);
    chk("valid_drop", key_valid, 0);
    chk("busy_release", busy, 1);
    chk("one_pulse", hs_n, h0 + 1);
    key_on = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (rows == 4'b0010 && n < 100);
    chk("release_time", n, 2 + DB);
    chk("resume_row2", rows, 4'b0100);
    chk("busy_after_rel", busy, 0);

    // bouncing '0' then stable
    key_row = 2'd3;
    key_mask = 4'b0010;
    sb.push_back(4'h0);
    h0 = hs_n;
    for (int i = 0; i < 70; i++) begin
      key_on = ~key_on;
      cyc(2);
    end
    chk("bounce_quiet", hs_n, h0);
    key_on = 1'b1;
    n = 0;
    while (hs_n == h0 && n < 300) begin cyc(1); n++; end
    chk("bounce_emit", hs_n, h0 + 1);
    key_on = 1'b0;
    wait_idle();
    cyc(20);
    chk("bounce_once", hs_n, h0 + 1);

    // back-pressure on 'A' (two columns, higher wins)
    key_ready = 1'b0;
    key_row = 2'd0;
    key_mask = 4'b1001;
    key_on = 1'b1;
    sb.push_back(4'hA);
    h0 = hs_n;
    wait_valid("bp_valid");
    for (int i = 0; i < 20; i++) begin
      chk("bp_held", key_valid, 1);
      chk("bp_code", key_code, 4'hA);
      cyc(1);
    end
    key_ready = 1'b1;
    cyc(1);
    chk("bp_drop", key_valid, 0);
    chk("bp_accept", hs_n, h0 + 1);
    key_on = 1'b0;
    wait_idle();

    // reset while a key is pending
    key_ready = 1'b0;
    key_row = 2'd2;
    key_mask = 4'b1000;
    key_on = 1'b1;
    h0 = hs_n;
    wait_valid("pre_rst_valid");
    cyc(3);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_rows", rows, 4'b0001);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_code", key_code, 4'h0);
    key_on = 1'b0;
    cyc(3);
    reset = 1'b1;
    key_ready = 1'b1;
    cyc(5);
    chk("rst_dropped", hs_n, h0);

    // long hold of '7'
    wait_row(4'b0100);
    key_row = 2'd2;
    key_mask = 4'b0001;
    key_on = 1'b1;
    h0 = hs_n;
    for (int i = 0; i < REP_N; i++) sb.push_back(4'h7);
    cyc(350);
    key_on = 1'b0;
    wait_idle();
    cyc(5);
    chk("hold_count", hs_n - h0, REP_N);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
